// File: rtl/hid_report_uart.sv
// Captures usb_hid_host reports into a frame FIFO and streams each as UART 8N1: SYNC, type, P0..P4, XOR checksum.
// Report in cycle N starts its start bit at N+2 when idle; no backpressure upstream, overflow drops and counts the report.
module hid_report_uart #(
    parameter int unsigned CLK_HZ = 12000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned DEPTH  = 8,
    parameter logic [7:0]  SYNC   = 8'hA5,
    parameter bit          DEDUP  = 1'b1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [1:0]               usb_type,
    input  logic                     usb_report,
    input  logic [7:0]               key_modifiers,
    input  logic [7:0]               key1,
    input  logic [7:0]               key2,
    input  logic [7:0]               key3,
    input  logic [7:0]               key4,
    input  logic [7:0]               mouse_btn,
    input  logic [7:0]               mouse_dx,
    input  logic [7:0]               mouse_dy,
    input  logic                     game_l,
    input  logic                     game_r,
    input  logic                     game_u,
    input  logic                     game_d,
    input  logic                     game_a,
    input  logic                     game_b,
    input  logic                     game_x,
    input  logic                     game_y,
    input  logic                     game_sel,
    input  logic                     game_sta,
    output logic                     uart_tx,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               drop_count,
    output logic                     busy
);
    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned LW  = AW + 1;

    typedef struct packed {
        logic [1:0] typ;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [7:0] p2;
        logic [7:0] p3;
        logic [7:0] p4;
    } entry_t;

    typedef enum logic {IDLE, SEND} state_t;

    entry_t            mem_q [DEPTH];
    entry_t            entry, head, hist_q, hist_d;
    logic              hist_vld_q, hist_vld_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [7:0]        drop_q, drop_d;
    state_t            state_q, state_d;
    logic [7:0][7:0]   frame_q, frame_d;
    logic [2:0]        byte_q, byte_d;
    logic [3:0]        bit_q, bit_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tx_q, tx_d;
    logic              rpt_vld, is_dup, accept, full, wr_en, pop;
    logic [7:0]        typ_byte, cur_byte;
    logic [2:0]        data_idx;

    always_comb begin
        entry     = '0;
        entry.typ = usb_type;
        case (usb_type)
            2'd1: begin
                entry.p0 = key_modifiers;
                entry.p1 = key1;
                entry.p2 = key2;
                entry.p3 = key3;
                entry.p4 = key4;
            end
            2'd2: begin
                entry.p0 = mouse_btn;
                entry.p1 = mouse_dx;
                entry.p2 = mouse_dy;
            end
            2'd3: begin
                entry.p0 = {game_l, game_r, game_u, game_d, game_a, game_b, game_x, game_y};
                entry.p1 = {6'b0, game_sel, game_sta};
            end
            default: ;
        endcase
    end

    assign rpt_vld = usb_report && (usb_type != 2'd0);
    assign is_dup  = DEDUP && hist_vld_q && (entry == hist_q);
    assign accept  = rpt_vld && !is_dup;
    // Full is judged on the level before any same-cycle pop.
    assign full    = (level_q == LW'(DEPTH));
    assign wr_en   = accept && !full;

    always_comb begin
        hist_d     = accept ? entry : hist_q;
        hist_vld_d = hist_vld_q | accept;
        wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q + LW'(wr_en) - LW'(pop);
        drop_d     = drop_q;
        if (accept && full && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        byte_d   = byte_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        head     = mem_q[rd_ptr_q];
        typ_byte = {6'b0, head.typ};
        case (state_q)
            IDLE: pop = (level_q != '0);
            SEND: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d = '0;
                    if (bit_q != 4'd9) begin
                        bit_d = bit_q + 4'd1;
                    end else begin
                        bit_d = 4'd0;
                        if (byte_q != 3'd7) begin
                            byte_d = byte_q + 3'd1;
                        end else if (level_q != '0) begin
                            pop = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            state_d = SEND;
            frame_d = {typ_byte ^ head.p0 ^ head.p1 ^ head.p2 ^ head.p3 ^ head.p4,
                       head.p4, head.p3, head.p2, head.p1, head.p0, typ_byte, SYNC};
            byte_d  = 3'd0;
            bit_d   = 4'd0;
            cnt_d   = '0;
        end
        // Line level is registered from next-state values so uart_tx is a clean flop output.
        cur_byte = frame_d[byte_d];
        data_idx = 3'(bit_d - 4'd1);
        if (state_d != SEND)     tx_d = 1'b1;
        else if (bit_d == 4'd0)  tx_d = 1'b0;
        else if (bit_d == 4'd9)  tx_d = 1'b1;
        else                     tx_d = cur_byte[data_idx];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hist_q     <= '0;
            hist_vld_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_q     <= '0;
            state_q    <= IDLE;
            frame_q    <= '0;
            byte_q     <= '0;
            bit_q      <= '0;
            cnt_q      <= '0;
            tx_q       <= 1'b1;
        end else begin
            hist_q     <= hist_d;
            hist_vld_q <= hist_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_q     <= drop_d;
            state_q    <= state_d;
            frame_q    <= frame_d;
            byte_q     <= byte_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && wr_en) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

    assign uart_tx    = tx_q;
    assign fifo_level = level_q;
    assign drop_count = drop_q;
    assign busy       = (state_q == SEND);
endmodule

// File: tb/tb_hid_report_uart.sv
// Directed bench: instance A at default parameters, instance B with DIV=4, DEPTH=4, DEDUP=0.
module tb_hid_report_uart;
    localparam int DIV_A = 104;
    localparam int DIV_B = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] usb_type;
    logic       report_a, report_b;
    logic [7:0] key_modifiers, key1, key2, key3, key4;
    logic [7:0] mouse_btn, mouse_dx, mouse_dy;
    logic       game_l, game_r, game_u, game_d, game_a, game_b, game_x, game_y, game_sel, game_sta;
    logic       tx_a, busy_a, tx_b, busy_b;
    logic [3:0] level_a;
    logic [2:0] level_b;
    logic [7:0] drop_a, drop_b;
    int         n_assert = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    hid_report_uart u_a (
        .clk(clk), .resetn(resetn), .usb_type(usb_type), .usb_report(report_a),
        .key_modifiers(key_modifiers), .key1(key1), .key2(key2), .key3(key3), .key4(key4),
        .mouse_btn(mouse_btn), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
        .game_l(game_l), .game_r(game_r), .game_u(game_u), .game_d(game_d), .game_a(game_a),
        .game_b(game_b), .game_x(game_x), .game_y(game_y), .game_sel(game_sel), .game_sta(game_sta),
        .uart_tx(tx_a), .fifo_level(level_a), .drop_count(drop_a), .busy(busy_a)
    );

    hid_report_uart #(.BAUD(3000000), .DEPTH(4), .DEDUP(1'b0)) u_b (
        .clk(clk), .resetn(resetn), .usb_type(usb_type), .usb_report(report_b),
        .key_modifiers(key_modifiers), .key1(key1), .key2(key2), .key3(key3), .key4(key4),
        .mouse_btn(mouse_btn), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
        .game_l(game_l), .game_r(game_r), .game_u(game_u), .game_d(game_d), .game_a(game_a),
        .game_b(game_b), .game_x(game_x), .game_y(game_y), .game_sel(game_sel), .game_sta(game_sta),
        .uart_tx(tx_b), .fifo_level(level_b), .drop_count(drop_b), .busy(busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic txs(input bit sel);
        return sel ? tx_b : tx_a;
    endfunction

    function automatic logic [63:0] frame_of(input logic [1:0] t, input logic [7:0] p0, input logic [7:0] p1,
                                             input logic [7:0] p2, input logic [7:0] p3, input logic [7:0] p4);
        logic [7:0] tb;
        tb = {6'b0, t};
        return {8'hA5, tb, p0, p1, p2, p3, p4, tb ^ p0 ^ p1 ^ p2 ^ p3 ^ p4};
    endfunction

    task automatic clear_fields();
        usb_type = 2'd0;
        {key_modifiers, key1, key2, key3, key4} = '0;
        {mouse_btn, mouse_dx, mouse_dy} = '0;
        {game_l, game_r, game_u, game_d, game_a, game_b, game_x, game_y, game_sel, game_sta} = '0;
    endtask

    task automatic set_kb(input logic [7:0] m, input logic [7:0] k1, input logic [7:0] k2,
                          input logic [7:0] k3, input logic [7:0] k4);
        clear_fields();
        usb_type = 2'd1;
        key_modifiers = m; key1 = k1; key2 = k2; key3 = k3; key4 = k4;
    endtask

    task automatic set_mouse(input logic [7:0] b, input logic [7:0] dx, input logic [7:0] dy);
        clear_fields();
        usb_type = 2'd2;
        mouse_btn = b; mouse_dx = dx; mouse_dy = dy;
    endtask

    // Entered on the first cycle of a start bit; leaves on the first cycle after the stop bit.
    task automatic recv_byte(input bit sel, input string tag, output logic [7:0] b, output logic busy_end);
        int div;
        div = sel ? DIV_B : DIV_A;
        b = '0;
        repeat (div / 2) tick();
        chk({tag, "_start"}, txs(sel), 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (div) tick();
            b[i] = txs(sel);
        end
        repeat (div) tick();
        chk({tag, "_stop"}, txs(sel), 1'b1);
        repeat (div - div / 2 - 1) tick();
        busy_end = sel ? busy_b : busy_a;
        tick();
    endtask

    task automatic recv_frame(input bit sel, input logic [63:0] exp, input string tag, output logic busy_end);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            recv_byte(sel, $sformatf("%s_b%0d", tag, i), b, busy_end);
            chk($sformatf("%s_byte%0d", tag, i), b, exp[63 - 8 * i -: 8]);
        end
    endtask

    task automatic wait_start(input bit sel, input int budget, input string tag, output int waited);
        waited = 0;
        while (txs(sel) !== 1'b0 && waited < budget) begin
            tick();
            waited++;
        end
        chk({tag, "_start_seen"}, txs(sel), 1'b0);
    endtask

    initial begin
        logic       be;
        int         w, zeros, peak;
        logic [63:0] f;
        resetn = 1'b0;
        report_a = 1'b0;
        report_b = 1'b0;
        clear_fields();
        repeat (3) tick();
        chk("rst_tx_a", tx_a, 1'b1);      chk("rst_level_a", level_a, 0);
        chk("rst_drop_a", drop_a, 0);     chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_tx_b", tx_b, 1'b1);      chk("rst_level_b", level_b, 0);
        chk("rst_drop_b", drop_b, 0);     chk("rst_busy_b", busy_b, 1'b0);
        resetn = 1'b1;
        tick();

        // Keyboard: latency, frame content and exact frame duration.
        set_kb(8'h02, 8'h04, 8'h00, 8'h00, 8'h00);
        report_a = 1'b1; tick(); report_a = 1'b0;
        chk("kb_level_n1", level_a, 1);
        tick();
        chk("kb_level_n2", level_a, 0);
        chk("kb_tx_n2", tx_a, 1'b0);
        chk("kb_busy_n2", busy_a, 1'b1);
        recv_frame(1'b0, 64'hA5_01_02_04_00_00_00_07, "kb", be);
        chk("kb_busy_last_cycle", be, 1'b1);
        chk("kb_busy_after", busy_a, 1'b0);
        chk("kb_tx_idle", tx_a, 1'b1);

        // Mouse with negative dx.
        set_mouse(8'h01, 8'hFF, 8'h02);
        report_a = 1'b1; tick(); report_a = 1'b0;
        wait_start(1'b0, 10, "ms", w);
        chk("ms_latency", w, 1);
        recv_frame(1'b0, 64'hA5_02_01_FF_02_00_00_FE, "ms", be);

        // Gamepad, with a type-0 report injected mid-frame.
        clear_fields();
        usb_type = 2'd3; game_a = 1'b1; game_sta = 1'b1;
        report_a = 1'b1; tick(); report_a = 1'b0;
        wait_start(1'b0, 10, "gp", w);
        fork
            recv_frame(1'b0, 64'hA5_03_08_01_00_00_00_0A, "gp", be);
            begin
                repeat (500) tick();
                clear_fields();
                report_a = 1'b1; tick(); report_a = 1'b0;
            end
        join
        chk("gp_busy_after", busy_a, 1'b0);
        chk("gp_level_after", level_a, 0);
        chk("gp_drop_after", drop_a, 0);
        zeros = 0;
        repeat (3 * DIV_A) begin
            tick();
            if (tx_a === 1'b0) zeros++;
        end
        chk("gp_no_extra_frame", zeros, 0);

        // Dedup enabled: X,X,X,Y on consecutive cycles gives two frames.
        fork
            begin
                set_kb(8'h00, 8'h05, 8'h00, 8'h00, 8'h00);
                report_a = 1'b1; repeat (3) tick();
                key1 = 8'h06; tick(); report_a = 1'b0;
                chk("dd_a_level", level_a, 1);
                chk("dd_a_drop", drop_a, 0);
            end
            begin
                wait_start(1'b0, 10, "dd_a0", w);
                chk("dd_a_latency", w, 2);
                recv_frame(1'b0, 64'hA5_01_00_05_00_00_00_04, "dd_a0", be);
                wait_start(1'b0, 10, "dd_a1", w);
                chk("dd_a_gap", w, 0);
                recv_frame(1'b0, 64'hA5_01_00_06_00_00_00_07, "dd_a1", be);
            end
        join
        chk("dd_a_busy_done", busy_a, 1'b0);
        chk("dd_a_level_done", level_a, 0);

        // Dedup disabled on B: same sequence gives four frames.
        fork
            begin
                set_kb(8'h00, 8'h05, 8'h00, 8'h00, 8'h00);
                report_b = 1'b1; repeat (3) tick();
                key1 = 8'h06; tick(); report_b = 1'b0;
                chk("dd_b_level", level_b, 3);
            end
            begin
                wait_start(1'b1, 10, "dd_b0", w);
                chk("dd_b_latency", w, 2);
                for (int k = 0; k < 4; k++) begin
                    if (k > 0) begin
                        wait_start(1'b1, 10, "dd_bk", w);
                        chk("dd_b_gap", w, 0);
                    end
                    f = (k < 3) ? 64'hA5_01_00_05_00_00_00_04 : 64'hA5_01_00_06_00_00_00_07;
                    recv_frame(1'b1, f, $sformatf("dd_b%0d", k), be);
                end
            end
        join
        chk("dd_b_busy_done", busy_b, 1'b0);
        chk("dd_b_level_done", level_b, 0);
        chk("dd_b_drop", drop_b, 0);

        // Overflow on DEPTH=4: six reports back to back, five frames, one drop.
        fork
            begin
                peak = 0;
                for (int i = 0; i < 6; i++) begin
                    set_kb(8'h00, 8'(16 + i), 8'h00, 8'h00, 8'h00);
                    report_b = 1'b1;
                    tick();
                    if (int'(level_b) > peak) peak = int'(level_b);
                end
                report_b = 1'b0;
                chk("dp_peak", peak, 4);
                chk("dp_drop", drop_b, 1);
                chk("dp_level_full", level_b, 4);
            end
            begin
                wait_start(1'b1, 10, "dp0", w);
                chk("dp_latency", w, 2);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) begin
                        wait_start(1'b1, 10, "dpk", w);
                        chk("dp_gap", w, 0);
                    end
                    recv_frame(1'b1, frame_of(2'd1, 8'h00, 8'(16 + k), 8'h00, 8'h00, 8'h00),
                               $sformatf("dp%0d", k), be);
                end
            end
        join
        chk("dp_busy_done", busy_b, 1'b0);
        chk("dp_level_done", level_b, 0);
        chk("dp_drop_kept", drop_b, 1);

        // Reset during byte 3 with two entries queued.
        set_kb(8'h00, 8'h21, 8'h00, 8'h00, 8'h00);
        report_a = 1'b1; tick();
        key1 = 8'h22; tick();
        key1 = 8'h23; tick();
        report_a = 1'b0;
        chk("rs_queued", level_a, 2);
        repeat (35 * DIV_A - 1) tick();
        chk("rs_busy_pre", busy_a, 1'b1);
        resetn = 1'b0;
        tick();
        chk("rs_tx", tx_a, 1'b1);
        chk("rs_level", level_a, 0);
        chk("rs_drop_a", drop_a, 0);
        chk("rs_drop_b", drop_b, 0);
        chk("rs_busy", busy_a, 1'b0);
        resetn = 1'b1;
        zeros = 0;
        repeat (12 * DIV_A) begin
            tick();
            if (tx_a === 1'b0 || busy_a === 1'b1) zeros++;
        end
        chk("rs_quiet", zeros, 0);
        chk("rs_level_quiet", level_a, 0);
        set_mouse(8'h00, 8'h10, 8'hF0);
        report_a = 1'b1; tick(); report_a = 1'b0;
        wait_start(1'b0, 10, "rs_new", w);
        chk("rs_new_latency", w, 1);
        recv_frame(1'b0, frame_of(2'd2, 8'h00, 8'h10, 8'hF0, 8'h00, 8'h00), "rs_new", be);
        chk("rs_new_busy_done", busy_a, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
